du_sequencer: RTL and testbench
===============================

Name: du_sequencer

Overview:
Hardware debug-unit sequencer that drives the PIPELINE debug interface in place of a bench. It loads a program into instruction memory, runs or single-steps the pipeline until halt or a cycle limit, then streams register-file and data-memory contents out over a valid/ready dump port. It sits between the host/UART command path and PIPELINE's i_du_*/o_du_* ports.

Parameters:
DATA_W, 32, width of instruction/data words
ADDR_W, 32, width of du address bus
IMEM_DEPTH, 256, max instruction words per LOAD
NUM_REGS, 32, registers emitted by DUMP_REGS
MAX_CYCLES, 1024, RUN watchdog limit in cycles
READ_LAT, 1, cycles from o_du_read_en to valid read data (>=1)

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous, active-high reset
i_cmd  in  3  0 LOAD, 1 RUN, 2 STEP, 3 DUMP_REGS, 4 DUMP_MEM; others illegal
i_cmd_arg  in  ADDR_W  LOAD: word count; DUMP_MEM: {count[15:0], base[15:0]}
i_cmd_valid / o_cmd_ready  in/out  1  command handshake
i_prog_data  in  DATA_W  program word
i_prog_valid / o_prog_ready  in/out  1  program stream handshake
o_du_data  out  DATA_W  to PIPELINE i_du_data
o_du_inst_addr_wr  out  ADDR_W  du write/read address (word index)
o_du_write_en, o_du_read_en  out  1  du strobes
o_pipe_en  out  1  pipeline advance enable
i_du_halt  in  1  PIPELINE o_du_halt
i_du_regs_mem_data, i_du_mem_data  in  DATA_W  debug read data
o_dump_data  out  DATA_W  dump word
o_dump_valid / i_dump_ready  out/in  1  dump handshake
o_busy, o_timeout, o_err  out  1  status; timeout/err sticky until next accepted command

Behaviour:
- All outputs registered; reset: every output 0, state IDLE, counters 0. Reset mid-operation aborts immediately; no partial dump word survives.
- States: IDLE, LOAD, RUN, STEP, DREQ, DWAIT, DOUT.
- IDLE: o_cmd_ready=1. Accept on valid&ready; clears o_timeout/o_err, sets o_busy next cycle. o_cmd_ready=0 in every other state.
- Illegal cmd, LOAD count 0 or >IMEM_DEPTH, DUMP_MEM count 0: set o_err, stay IDLE, no du activity.
- LOAD (N words): o_prog_ready=1; each accepted word k drives o_du_write_en=1, o_du_data=word, addr=k on the following cycle. One write per cycle max; gaps in i_prog_valid produce write_en=0 cycles. After word N-1 -> IDLE. o_pipe_en=0 throughout.
- RUN: o_pipe_en=1 from cycle after accept. Stop when i_du_halt sampled 1 (o_pipe_en drops next cycle) or counter reaches MAX_CYCLES (o_timeout=1). Halt already 1 at entry -> zero enabled cycles. -> IDLE.
- STEP: o_pipe_en=1 for exactly one cycle, then IDLE, regardless of halt.
- DUMP_REGS/DUMP_MEM: per index i: DREQ drives o_du_read_en=1, addr=base+i (base 0 for regs) for one cycle; DWAIT waits READ_LAT cycles; capture i_du_regs_mem_data (regs) or i_du_mem_data (mem) into o_dump_data; DOUT holds o_dump_valid=1 and data stable until i_dump_ready; next index issued the cycle after handshake. After last index -> IDLE. Address arithmetic modulo 2^ADDR_W (wrap).
- o_busy=1 in every state but IDLE.

Optional Feature:
DU_SEQUENCER_CYCLE_COUNT_EN: defined -> RUN completion emits one extra dump word holding the enabled-cycle count (zero-extended) with normal backpressure before IDLE, and the count stays readable via port o_cycle_count [DATA_W]. Undefined -> no extra word; port absent.

Decomposition:
- Package du_seq_pkg: command encodings, FSM state enum, DUMP_MEM arg field positions.
- Sub-module du_dump_out: one-entry valid/ready output register (load, hold, clear on reset).

Test Plan:
- LOAD count 3, words 0x24080005/0x24090007/0xFC000000, valid gaps -> exactly 3 write_en pulses at addr 0,1,2 with matching data; then IDLE, ready=1.
- RUN with halt raised after 7 enabled cycles -> o_pipe_en high exactly 7 cycles, o_timeout=0; with CYCLE_COUNT_EN dump word 7.
- RUN, halt never asserted, MAX_CYCLES=16 -> 16 enabled cycles, o_timeout=1, cleared by next command.
- DUMP_REGS with reg8=5, i_dump_ready low 3 cycles on word 8 -> 32 words in order, word 8 = 0x00000005 stable during stall.
- DUMP_MEM arg count 4 base 0xFFFE -> reads addr 0xFFFE,0xFFFF,0x10000,0x10001; cmd LOAD count 0 -> o_err=1, no du strobes.
- Reset asserted mid-DUMP_REGS at word 10 -> all outputs 0 same cycle, IDLE; fresh DUMP_REGS restarts at reg 0.

Source files
------------

// File: rtl/du_seq_pkg.sv
// du_seq_pkg: shared definitions for the debug-unit sequencer.
//   - command encodings carried on i_cmd
//   - sequencer FSM state enum
//   - DUMP_MEM argument field layout ({count[15:0], base[15:0]})
package du_seq_pkg;

  localparam logic [2:0] CMD_LOAD      = 3'd0;
  localparam logic [2:0] CMD_RUN       = 3'd1;
  localparam logic [2:0] CMD_STEP      = 3'd2;
  localparam logic [2:0] CMD_DUMP_REGS = 3'd3;
  localparam logic [2:0] CMD_DUMP_MEM  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_STEP,
    S_DREQ,
    S_DWAIT,
    S_DOUT
  } state_e;

  localparam int DM_FIELD_W  = 16;
  localparam int DM_BASE_LSB = 0;
  localparam int DM_CNT_LSB  = 16;

endpackage

// File: rtl/du_dump_out.sv
// du_dump_out: one-entry valid/ready output register for the dump port.
//   clk, rst       : clock, asynchronous active-high reset (clears valid and data)
//   load/load_data : capture a new word and raise valid (only issued while empty)
//   ready          : consumer accept; valid drops after valid&ready
//   valid/data     : registered dump outputs, data held stable while stalled
module du_dump_out #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/du_sequencer.sv
// du_sequencer: drives the PIPELINE debug interface. Loads a program into
// instruction memory, runs/single-steps the pipeline, and streams register
// file or data memory contents out over a valid/ready dump port.
// Ports:
//   i_clk, i_reset                 : clock, asynchronous active-high reset
//   i_cmd/i_cmd_arg/i_cmd_valid    : command in (LOAD, RUN, STEP, DUMP_REGS, DUMP_MEM)
//   o_cmd_ready                    : high only in IDLE
//   i_prog_data/valid, o_prog_ready: program word stream for LOAD
//   o_du_data, o_du_inst_addr_wr   : debug write data / read-write word address
//   o_du_write_en, o_du_read_en    : debug strobes
//   o_pipe_en                      : pipeline advance enable
//   i_du_halt                      : pipeline halted
//   i_du_regs_mem_data, i_du_mem_data : debug read data (regfile / data memory)
//   o_dump_data/valid, i_dump_ready: dump stream
//   o_busy, o_timeout, o_err       : status (timeout/err sticky until next accepted command)
// Optional: DU_SEQUENCER_CYCLE_COUNT_EN appends the enabled-cycle count as an
// extra dump word after RUN and exposes it on o_cycle_count.
module du_sequencer
  import du_seq_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int IMEM_DEPTH = 256,
  parameter int NUM_REGS   = 32,
  parameter int MAX_CYCLES = 1024,
  parameter int READ_LAT   = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [2:0]        i_cmd,
  input  logic [ADDR_W-1:0] i_cmd_arg,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [DATA_W-1:0] i_prog_data,
  input  logic              i_prog_valid,
  output logic              o_prog_ready,
  output logic [DATA_W-1:0] o_du_data,
  output logic [ADDR_W-1:0] o_du_inst_addr_wr,
  output logic              o_du_write_en,
  output logic              o_du_read_en,
  output logic              o_pipe_en,
  input  logic              i_du_halt,
  input  logic [DATA_W-1:0] i_du_regs_mem_data,
  input  logic [DATA_W-1:0] i_du_mem_data,
  output logic [DATA_W-1:0] o_dump_data,
  output logic              o_dump_valid,
  input  logic              i_dump_ready,
  output logic              o_busy,
  output logic              o_timeout,
  output logic              o_err
`ifdef DU_SEQUENCER_CYCLE_COUNT_EN
  ,
  output logic [DATA_W-1:0] o_cycle_count
`endif
);

  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam int LW = $clog2(READ_LAT + 1);

  state_e            state;
  logic [ADDR_W-1:0] cnt, idx, base;
  logic              src_mem;   // dump source: 0 regfile, 1 data memory
  logic [CW-1:0]     cyc;       // enabled cycles completed before the current one
  logic [LW-1:0]     wcnt;
`ifdef DU_SEQUENCER_CYCLE_COUNT_EN
  logic              run_dump;  // DOUT is carrying the RUN cycle-count word
`endif

  logic              cmd_acc, cmd_ok, prog_acc, dump_hs;
  logic              last_idx, dump_last, wait_done, run_stop;
  logic [ADDR_W-1:0] idx_nxt, dm_base, dm_cnt;
  logic [CW-1:0]     run_total;
  logic              dload;
  logic [DATA_W-1:0] dload_data;

  always_comb begin
    cmd_acc   = i_cmd_valid && o_cmd_ready;
    prog_acc  = i_prog_valid && o_prog_ready;
    dump_hs   = o_dump_valid && i_dump_ready;
    dm_base   = ADDR_W'(i_cmd_arg[DM_BASE_LSB +: DM_FIELD_W]);
    dm_cnt    = ADDR_W'(i_cmd_arg[DM_CNT_LSB +: DM_FIELD_W]);
    idx_nxt   = idx + ADDR_W'(1);
    last_idx  = (idx == cnt - ADDR_W'(1));
    dump_last = last_idx;
`ifdef DU_SEQUENCER_CYCLE_COUNT_EN
    dump_last = last_idx || run_dump;
`endif
    wait_done = (state == S_DWAIT) && (wcnt == LW'(READ_LAT));
    // pipe_en low inside RUN only happens when halt was already up at entry
    run_total = cyc + CW'(o_pipe_en);
    run_stop  = (state == S_RUN) &&
                (!o_pipe_en || i_du_halt || run_total == CW'(MAX_CYCLES));
    case (i_cmd)
      CMD_LOAD:      cmd_ok = (i_cmd_arg != '0) && (i_cmd_arg <= ADDR_W'(IMEM_DEPTH));
      CMD_RUN,
      CMD_STEP,
      CMD_DUMP_REGS: cmd_ok = 1'b1;
      CMD_DUMP_MEM:  cmd_ok = (dm_cnt != '0);
      default:       cmd_ok = 1'b0;
    endcase
    dload      = wait_done;
    dload_data = src_mem ? i_du_mem_data : i_du_regs_mem_data;
`ifdef DU_SEQUENCER_CYCLE_COUNT_EN
    if (run_stop) begin
      dload      = 1'b1;
      dload_data = DATA_W'(run_total);
    end
`endif
  end

  du_dump_out #(.W(DATA_W)) u_dump_out (
    .clk       (i_clk),
    .rst       (i_reset),
    .load      (dload),
    .load_data (dload_data),
    .ready     (i_dump_ready),
    .valid     (o_dump_valid),
    .data      (o_dump_data)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state             <= S_IDLE;
      cnt               <= '0;
      idx               <= '0;
      base              <= '0;
      src_mem           <= 1'b0;
      cyc               <= '0;
      wcnt              <= '0;
      o_cmd_ready       <= 1'b0;
      o_prog_ready      <= 1'b0;
      o_du_data         <= '0;
      o_du_inst_addr_wr <= '0;
      o_du_write_en     <= 1'b0;
      o_du_read_en      <= 1'b0;
      o_pipe_en         <= 1'b0;
      o_busy            <= 1'b0;
      o_timeout         <= 1'b0;
      o_err             <= 1'b0;
`ifdef DU_SEQUENCER_CYCLE_COUNT_EN
      run_dump          <= 1'b0;
      o_cycle_count     <= '0;
`endif
    end else begin
      o_du_write_en <= 1'b0;
      o_du_read_en  <= 1'b0;
      case (state)
        S_IDLE: begin
          o_cmd_ready <= 1'b1;
          if (cmd_acc) begin
            o_timeout <= 1'b0;
            o_err     <= !cmd_ok;
            if (cmd_ok) begin
              o_cmd_ready <= 1'b0;
              o_busy      <= 1'b1;
              case (i_cmd)
                CMD_LOAD: begin
                  state        <= S_LOAD;
                  cnt          <= i_cmd_arg;
                  idx          <= '0;
                  o_prog_ready <= 1'b1;
                end
                CMD_RUN: begin
                  state     <= S_RUN;
                  cyc       <= '0;
                  o_pipe_en <= !i_du_halt;
                end
                CMD_STEP: begin
                  state     <= S_STEP;
                  o_pipe_en <= 1'b1;
                end
                CMD_DUMP_REGS: begin
                  state             <= S_DREQ;
                  base              <= '0;
                  cnt               <= ADDR_W'(NUM_REGS);
                  idx               <= '0;
                  src_mem           <= 1'b0;
                  o_du_read_en      <= 1'b1;
                  o_du_inst_addr_wr <= '0;
                end
                default: begin  // CMD_DUMP_MEM (only legal remaining)
                  state             <= S_DREQ;
                  base              <= dm_base;
                  cnt               <= dm_cnt;
                  idx               <= '0;
                  src_mem           <= 1'b1;
                  o_du_read_en      <= 1'b1;
                  o_du_inst_addr_wr <= dm_base;
                end
              endcase
            end
          end
        end
        S_LOAD: begin
          if (prog_acc) begin
            o_du_write_en     <= 1'b1;
            o_du_data         <= i_prog_data;
            o_du_inst_addr_wr <= idx;
            idx               <= idx_nxt;
            if (last_idx) begin
              state        <= S_IDLE;
              o_prog_ready <= 1'b0;
              o_cmd_ready  <= 1'b1;
              o_busy       <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (run_stop) begin
            o_pipe_en <= 1'b0;
            o_timeout <= o_pipe_en && !i_du_halt;
`ifdef DU_SEQUENCER_CYCLE_COUNT_EN
            o_cycle_count <= DATA_W'(run_total);
            run_dump      <= 1'b1;
            state         <= S_DOUT;
`else
            state       <= S_IDLE;
            o_cmd_ready <= 1'b1;
            o_busy      <= 1'b0;
`endif
          end else begin
            cyc <= run_total;
          end
        end
        S_STEP: begin
          o_pipe_en   <= 1'b0;
          state       <= S_IDLE;
          o_cmd_ready <= 1'b1;
          o_busy      <= 1'b0;
        end
        S_DREQ: begin
          state <= S_DWAIT;
          wcnt  <= LW'(1);
        end
        S_DWAIT: begin
          if (wait_done) state <= S_DOUT;
          else           wcnt  <= wcnt + LW'(1);
        end
        S_DOUT: begin
          if (dump_hs) begin
            if (dump_last) begin
              state       <= S_IDLE;
              o_cmd_ready <= 1'b1;
              o_busy      <= 1'b0;
`ifdef DU_SEQUENCER_CYCLE_COUNT_EN
              run_dump    <= 1'b0;
`endif
            end else begin
              idx               <= idx_nxt;
              o_du_read_en      <= 1'b1;
              o_du_inst_addr_wr <= base + idx_nxt;
              state             <= S_DREQ;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_du_sequencer.sv
// tb_du_sequencer: directed/randomized bench for du_sequencer with a simple
// pipeline read model and a behavioural expectation model.
module tb_du_sequencer;
  import du_seq_pkg::*;

  localparam int MAXC = 16;

  logic        i_clk = 1'b0, i_reset = 1'b1;
  logic [2:0]  i_cmd = '0;
  logic [31:0] i_cmd_arg = '0;
  logic        i_cmd_valid = 1'b0, o_cmd_ready;
  logic [31:0] i_prog_data = '0;
  logic        i_prog_valid = 1'b0, o_prog_ready;
  logic [31:0] o_du_data, o_du_inst_addr_wr;
  logic        o_du_write_en, o_du_read_en, o_pipe_en;
  logic        i_du_halt = 1'b0;
  logic [31:0] i_du_regs_mem_data, i_du_mem_data;
  logic [31:0] o_dump_data;
  logic        o_dump_valid, i_dump_ready = 1'b0;
  logic        o_busy, o_timeout, o_err;
`ifdef DU_SEQUENCER_CYCLE_COUNT_EN
  logic [31:0] o_cycle_count;
`endif

  du_sequencer #(.MAX_CYCLES(MAXC)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_cmd(i_cmd), .i_cmd_arg(i_cmd_arg), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_prog_data(i_prog_data), .i_prog_valid(i_prog_valid), .o_prog_ready(o_prog_ready),
    .o_du_data(o_du_data), .o_du_inst_addr_wr(o_du_inst_addr_wr),
    .o_du_write_en(o_du_write_en), .o_du_read_en(o_du_read_en), .o_pipe_en(o_pipe_en),
    .i_du_halt(i_du_halt), .i_du_regs_mem_data(i_du_regs_mem_data), .i_du_mem_data(i_du_mem_data),
    .o_dump_data(o_dump_data), .o_dump_valid(o_dump_valid), .i_dump_ready(i_dump_ready),
    .o_busy(o_busy), .o_timeout(o_timeout), .o_err(o_err)
`ifdef DU_SEQUENCER_CYCLE_COUNT_EN
    , .o_cycle_count(o_cycle_count)
`endif
  );

  always #5 i_clk = ~i_clk;

  int checks = 0, failures = 0;

  logic [31:0] regfile [32];
  logic [31:0] prog_words [16];

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a * 32'h9E3779B1 + 32'h0000_0101;
  endfunction

  // Pipeline debug-read model: data valid READ_LAT(=1) cycle after read_en.
  logic        rd_vld;
  logic [31:0] rd_addr;
  always @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rd_vld  <= 1'b0;
      rd_addr <= '0;
    end else begin
      rd_vld <= o_du_read_en;
      if (o_du_read_en) rd_addr <= o_du_inst_addr_wr;
    end
  end
  assign i_du_regs_mem_data = rd_vld ? regfile[rd_addr[4:0]] : 32'hDEADBEEF;
  assign i_du_mem_data      = rd_vld ? mem_val(rd_addr)      : 32'hDEADBEEF;

  logic [31:0] got_q[$], rd_q[$], wr_a[$], wr_d[$], run_words[$];
  int run_en, stray;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] c, input logic [31:0] a);
    int n = 0;
    while (!o_cmd_ready && n < 50) begin tick(); n++; end
    if (!o_cmd_ready) chk("cmd_ready_wait", 64'(o_cmd_ready), 64'(1));
    i_cmd = c; i_cmd_arg = a; i_cmd_valid = 1'b1;
    tick();
    i_cmd_valid = 1'b0;
  endtask

  task automatic do_load(input int n);
    int k = 0;
    logic acc;
    wr_a.delete(); wr_d.delete(); stray = 0;
    send_cmd(CMD_LOAD, 32'(n));
    for (int c = 0; c < 300; c++) begin
      if (o_du_write_en) begin wr_a.push_back(o_du_inst_addr_wr); wr_d.push_back(o_du_data); end
      if (o_pipe_en || o_du_read_en) stray++;
      if (k == n && o_cmd_ready) break;
      if (k < n) begin
        i_prog_valid = ($urandom_range(0, 2) != 0);
        i_prog_data  = prog_words[k];
      end else i_prog_valid = 1'b0;
      acc = i_prog_valid && o_prog_ready;
      tick();
      if (acc) k++;
    end
    i_prog_valid = 1'b0;
    chk("load_done", 64'(o_cmd_ready), 64'(1));
    chk("load_nwrites", 64'(wr_a.size()), 64'(n));
    chk("load_stray", 64'(stray), 64'(0));
    chk("load_prog_ready", 64'(o_prog_ready), 64'(0));
    for (int i = 0; i < wr_a.size() && i < n; i++) begin
      chk("load_addr", 64'(wr_a[i]), 64'(i));
      chk("load_data", 64'(wr_d[i]), 64'(prog_words[i]));
    end
  endtask

  // halt_after: >0 halt once that many cycles ran, 0 never, <0 halt at entry
  task automatic do_run(input int halt_after);
    run_en = 0; run_words.delete();
    i_du_halt = (halt_after < 0);
    i_dump_ready = 1'b1;
    send_cmd(CMD_RUN, 32'd0);
    for (int c = 0; c < 200; c++) begin
      if (o_cmd_ready) break;
      if (o_pipe_en) run_en++;
      if (o_dump_valid) run_words.push_back(o_dump_data);
      if (halt_after > 0 && run_en >= halt_after) i_du_halt = 1'b1;
      tick();
    end
    chk("run_done", 64'(o_cmd_ready), 64'(1));
    i_du_halt = 1'b0; i_dump_ready = 1'b0;
`ifdef DU_SEQUENCER_CYCLE_COUNT_EN
    chk("run_cnt_words", 64'(run_words.size()), 64'(1));
    if (run_words.size() > 0) chk("run_cnt_word", 64'(run_words[0]), 64'(run_en));
    chk("run_cnt_port", 64'(o_cycle_count), 64'(run_en));
`endif
  endtask

  task automatic collect_dump(input int stall_idx);
    int stall = 0;
    logic [31:0] held = '0;
    got_q.delete(); rd_q.delete(); stray = 0;
    for (int c = 0; c < 2000; c++) begin
      if (o_du_read_en) rd_q.push_back(o_du_inst_addr_wr);
      if (o_du_write_en || o_pipe_en) stray++;
      if (o_cmd_ready) break;
      if (o_dump_valid) begin
        if (got_q.size() == stall_idx && stall < 3) begin
          if (stall == 0) held = o_dump_data;
          else chk("stall_hold", 64'(o_dump_data), 64'(held));
          i_dump_ready = 1'b0;
          stall++;
        end else i_dump_ready = ($urandom_range(0, 3) != 0);
        if (i_dump_ready) got_q.push_back(o_dump_data);
      end else i_dump_ready = 1'($urandom_range(0, 1));
      tick();
    end
    i_dump_ready = 1'b0;
    chk("dump_done", 64'(o_cmd_ready), 64'(1));
    chk("dump_stray", 64'(stray), 64'(0));
  endtask

  task automatic check_mem_dump(input logic [15:0] b, input int n);
    send_cmd(CMD_DUMP_MEM, {16'(n), b});
    collect_dump(-1);
    chk("mem_nwords", 64'(got_q.size()), 64'(n));
    chk("mem_nreads", 64'(rd_q.size()), 64'(n));
    for (int i = 0; i < n && i < got_q.size() && i < rd_q.size(); i++) begin
      chk("mem_addr", 64'(rd_q[i]), 64'(32'(b) + 32'(i)));
      chk("mem_word", 64'(got_q[i]), 64'(mem_val(32'(b) + 32'(i))));
    end
  endtask

  logic [2:0]  bad_cmd [5] = '{CMD_LOAD, CMD_LOAD, 3'd6, 3'd7, CMD_DUMP_MEM};
  logic [31:0] bad_arg [5] = '{32'd0, 32'd257, 32'd0, 32'd5, 32'h0000_0010};

  initial begin
    int n, ha, en;
    for (int i = 0; i < 32; i++) regfile[i] = $urandom;
    regfile[8] = 32'h0000_0005;
    prog_words[0] = 32'h24080005; prog_words[1] = 32'h24090007; prog_words[2] = 32'hFC000000;

    // reset state
    #12;
    chk("rst_du", 64'({o_du_data, o_du_inst_addr_wr}), 64'(0));
    chk("rst_dump", 64'({o_dump_data, o_dump_valid}), 64'(0));
    chk("rst_status", 64'({o_du_write_en, o_du_read_en, o_pipe_en, o_busy, o_timeout, o_err,
                           o_cmd_ready, o_prog_ready}), 64'(0));
    i_reset = 1'b0;
    tick();
    chk("idle_ready", 64'({o_cmd_ready, o_busy}), 64'(2'b10));

    // LOAD: fixed program then a random one
    do_load(3);
    for (int i = 0; i < 6; i++) prog_words[i] = $urandom;
    do_load(6);

    // RUN variants
    do_run(7);
    chk("run7_en", 64'(run_en), 64'(7));
    chk("run7_to", 64'(o_timeout), 64'(0));
    ha = $urandom_range(2, 12);
    do_run(ha);
    chk("runr_en", 64'(run_en), 64'(ha));
    do_run(-1);
    chk("run_entry_halt_en", 64'(run_en), 64'(0));
    chk("run_entry_halt_to", 64'(o_timeout), 64'(0));
    do_run(0);
    chk("run_to_en", 64'(run_en), 64'(MAXC));
    chk("run_to_flag", 64'(o_timeout), 64'(1));
    tick(); tick();
    chk("run_to_sticky", 64'(o_timeout), 64'(1));

    // STEP clears sticky status and pulses pipe_en once
    send_cmd(CMD_STEP, 32'd0);
    chk("step_clr", 64'({o_timeout, o_err, o_busy}), 64'(3'b001));
    en = 0;
    for (int c = 0; c < 4; c++) begin if (o_pipe_en) en++; tick(); end
    chk("step_en", 64'(en), 64'(1));

    // illegal / zero-count commands
    for (int t = 0; t < 5; t++) begin
      send_cmd(bad_cmd[t], bad_arg[t]);
      stray = 0;
      for (int c = 0; c < 3; c++) begin
        if (o_du_write_en || o_du_read_en || o_pipe_en || o_prog_ready || o_busy) stray++;
        tick();
      end
      chk("err_flag", 64'(o_err), 64'(1));
      chk("err_quiet", 64'(stray), 64'(0));
    end

    // DUMP_REGS with a 3-cycle stall on word 8
    send_cmd(CMD_DUMP_REGS, 32'd0);
    chk("dump_clr_err", 64'({o_err, o_busy}), 64'(2'b01));
    collect_dump(8);
    chk("regs_nwords", 64'(got_q.size()), 64'(32));
    for (int i = 0; i < 32 && i < got_q.size() && i < rd_q.size(); i++) begin
      chk("regs_addr", 64'(rd_q[i]), 64'(i));
      chk("regs_word", 64'(got_q[i]), 64'(regfile[i]));
    end

    // DUMP_MEM across the 16-bit base boundary, then random
    check_mem_dump(16'hFFFE, 4);
    check_mem_dump(16'($urandom), $urandom_range(1, 5));

    // reset in the middle of a register dump
    send_cmd(CMD_DUMP_REGS, 32'd0);
    n = 0;
    for (int c = 0; c < 500 && n < 10; c++) begin
      i_dump_ready = 1'b1;
      if (o_dump_valid) n++;
      tick();
    end
    chk("mid_reached", 64'(n), 64'(10));
    i_reset = 1'b1;
    #1;
    chk("mid_rst_du", 64'({o_du_data, o_du_inst_addr_wr}), 64'(0));
    chk("mid_rst_dump", 64'({o_dump_data, o_dump_valid}), 64'(0));
    chk("mid_rst_status", 64'({o_du_write_en, o_du_read_en, o_pipe_en, o_busy, o_timeout, o_err,
                               o_cmd_ready, o_prog_ready}), 64'(0));
    #1;
    i_reset = 1'b0; i_dump_ready = 1'b0;
    tick();
    chk("mid_idle", 64'({o_cmd_ready, o_busy}), 64'(2'b10));
    send_cmd(CMD_DUMP_REGS, 32'd0);
    collect_dump(-1);
    chk("fresh_nwords", 64'(got_q.size()), 64'(32));
    if (rd_q.size() > 0) chk("fresh_addr0", 64'(rd_q[0]), 64'(0));
    if (got_q.size() > 0) chk("fresh_word0", 64'(got_q[0]), 64'(regfile[0]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
